mdc_out_collector: RTL

- Downstream stage of the multi-dataflow MAC kernel network; consumes its output stream port (outStream0_data/wr/full).
- Collects exactly `len` result words per job into a local FIFO and forwards them on a valid/ready master stream toward the accelerator streamer.
- Tags the final word with `last`, pulses `done` when that word is handshaked, and flags protocol errors.

---
 rtl/mdc_out_pkg.sv | 21 ++
 rtl/mdc_out_fifo.sv | 62 ++++++
 rtl/mdc_out_collector.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mdc_out_pkg.sv
// Shared types and default sizes for the MAC kernel output collector.
package mdc_out_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_DEPTH   = 8;
    localparam int unsigned DEF_LEN_W   = 16;
    localparam int unsigned DEF_ENTRY_W = DEF_DATA_W + 1;

    // Job sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // FIFO entry is the data word plus the last tag on top
    function automatic int unsigned entry_width(input int unsigned data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/mdc_out_fifo.sv
// Synchronous first-word-fall-through FIFO, pointer-plus-count organisation.
module mdc_out_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 33
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // Guard against writing a full or reading an empty FIFO
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy; power-of-2 depth lets pointers wrap naturally
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mdc_out_collector.sv
// Collects a fixed-length job of kernel result words and forwards them on a
// valid/ready stream, tagging the final word and reporting completion/errors.
module mdc_out_collector
    import mdc_out_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_wr,
    output logic              in_full,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              err_clr,
    output logic [LEN_W-1:0]  acc_cnt
);

    localparam int unsigned ENTRY_W = entry_width(DATA_W);

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   acc_cnt_q;
    logic [LEN_W-1:0]   acc_cnt_d;
    logic [LEN_W-1:0]   out_cnt_q;
    logic               done_q;
    logic               err_q;
    logic               err_d;

    logic               wr_acc;
    logic               wr_drop;
    logic               last_tag;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;

    // Back-pressure comes from registered state only, never from in_wr
    assign in_full  = (state_q != ST_RUN) | fifo_full;
    assign wr_acc   = in_wr & ~in_full;
    assign wr_drop  = in_wr & in_full;

    assign acc_cnt_d  = acc_cnt_q + LEN_W'(1);
    assign last_tag   = (acc_cnt_d == len_q);
    assign fifo_push  = wr_acc;
    assign fifo_wdata = {last_tag, in_data};

    // Output side reads the FIFO head directly; idle outputs are forced low
    assign m_valid  = ~fifo_empty;
    assign fifo_pop = m_valid & m_ready;
    assign m_data   = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
    assign m_last   = ~fifo_empty & fifo_rdata[DATA_W];

    // A new drop wins over a simultaneous clear
    assign err_d = wr_drop | (err_q & ~err_clr);

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign acc_cnt = acc_cnt_q;

    mdc_out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Job sequencer: accept len words, then wait for the tagged word to leave
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            acc_cnt_q <= '0;
            out_cnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= err_d;
            if (fifo_pop) begin
                out_cnt_q <= out_cnt_q + LEN_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            len_q     <= len;
                            acc_cnt_q <= '0;
                            out_cnt_q <= '0;
                            state_q   <= ST_RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (wr_acc) begin
                        acc_cnt_q <= acc_cnt_d;
                        if (last_tag) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fifo_pop && m_last) begin
                        assert (out_cnt_q + LEN_W'(1) == len_q);
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
